// File: rtl/y86_pkg.sv
// Shared encodings for the y86 ALU arbiter.
// Holds the function codes, the condition-code bit layout and the condition-code reset value.
package y86_pkg;

   typedef enum logic [1:0] {
      FN_ADD = 2'd0,
      FN_SUB = 2'd1,
      FN_AND = 2'd2,
      FN_XOR = 2'd3
   } aluFn_e;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slotState_e;

   // cc is ordered {ZF, SF, OF}
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   localparam logic [2:0] CC_RESET = 3'b100;

   function automatic logic [2:0] packCc(input logic zf, input logic sf, input logic of);
      logic [2:0] c;
      c        = 3'b000;
      c[CC_ZF] = zf;
      c[CC_SF] = sf;
      c[CC_OF] = of;
      return c;
   endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: ADD (b+a), SUB (b-a), AND, XOR, with optional ZF/SF/OF flag outputs.
// With FLAGS_EN=0 the flag outputs are tied low and no flag logic is built.
module alu_core
   import y86_pkg::*;
#(
   parameter int W        = 64,
   parameter bit FLAGS_EN = 1'b1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [1:0]   fn,
   output logic [W-1:0] result,
   output logic         zf,
   output logic         sf,
   output logic         of
);

   always_comb begin
      result = '0;
      case (aluFn_e'(fn))
         FN_ADD:  result = b + a;
         FN_SUB:  result = b - a;
         FN_AND:  result = a & b;
         FN_XOR:  result = a ^ b;
         default: result = '0;
      endcase
   end

   generate
      if (FLAGS_EN) begin : gFlags
         // Overflow is judged from operand and result signs only; logic ops never overflow.
         always_comb begin
            of = 1'b0;
            case (aluFn_e'(fn))
               FN_ADD:  of = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
               FN_SUB:  of = (a[W-1] != b[W-1]) && (result[W-1] != b[W-1]);
               default: of = 1'b0;
            endcase
         end
         assign zf = (result == '0);
         assign sf = result[W-1];
      end else begin : gNoFlags
         assign zf = 1'b0;
         assign sf = 1'b0;
         assign of = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/alu_arb.sv
// Two-requester round-robin front end for a shared ALU with a one-entry registered result slot.
// Define ALU_ARB_CC_EN to add the {ZF,SF,OF} condition-code register and setcc handling.
module alu_arb
   import y86_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic         req1_valid,
   output logic         req0_ready,
   output logic         req1_ready,
   input  logic [1:0]   req0_fn,
   input  logic [1:0]   req1_fn,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic         req0_setcc,
   input  logic         req1_setcc,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         res_id,
   output logic [W-1:0] res_data,
   output logic [2:0]   cc
);

`ifdef ALU_ARB_CC_EN
   localparam bit CcEn = 1'b1;
`else
   localparam bit CcEn = 1'b0;
`endif

   slotState_e   state_q;
   logic [W-1:0] resData_q;
   logic         resId_q;
   logic         rrPtr_q;

   logic         canGrant;
   logic         gnt0;
   logic         gnt1;
   logic         accept;
   logic [W-1:0] opA;
   logic [W-1:0] opB;
   logic [1:0]   opFn;
   logic [W-1:0] aluResult;
   logic         aluZf;
   logic         aluSf;
   logic         aluOf;

   // A full slot can only take a new op when it drains in the same cycle.
   assign canGrant = !rst && ((state_q == SLOT_EMPTY) || res_ready);
   assign gnt0     = canGrant && req0_valid && (!req1_valid || !rrPtr_q);
   assign gnt1     = canGrant && req1_valid && (!req0_valid ||  rrPtr_q);
   assign accept   = gnt0 || gnt1;

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   assign opA  = gnt1 ? req1_a  : req0_a;
   assign opB  = gnt1 ? req1_b  : req0_b;
   assign opFn = gnt1 ? req1_fn : req0_fn;

   alu_core #(
      .W        (W),
      .FLAGS_EN (CcEn)
   ) uAluCore (
      .a      (opA),
      .b      (opB),
      .fn     (opFn),
      .result (aluResult),
      .zf     (aluZf),
      .sf     (aluSf),
      .of     (aluOf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= SLOT_EMPTY;
         resData_q <= '0;
         resId_q   <= 1'b0;
         rrPtr_q   <= 1'b0;
      end else begin
         case (state_q)
            SLOT_EMPTY: begin
               if (accept) begin
                  state_q   <= SLOT_FULL;
                  resData_q <= aluResult;
                  resId_q   <= gnt1;
                  rrPtr_q   <= gnt0;
               end
            end
            SLOT_FULL: begin
               if (accept) begin
                  resData_q <= aluResult;
                  resId_q   <= gnt1;
                  rrPtr_q   <= gnt0;
               end else if (res_ready) begin
                  state_q <= SLOT_EMPTY;
               end
            end
            default: state_q <= SLOT_EMPTY;
         endcase
      end
   end

   assign res_valid = (state_q == SLOT_FULL);
   assign res_id    = resId_q;
   assign res_data  = resData_q;

`ifdef ALU_ARB_CC_EN
   logic [2:0] cc_q;
   logic [2:0] cc_d;
   logic       gntSetcc;

   assign gntSetcc = gnt1 ? req1_setcc : req0_setcc;
   assign cc_d     = (accept && gntSetcc) ? packCc(aluZf, aluSf, aluOf) : cc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cc_q <= CC_RESET;
      end else begin
         cc_q <= cc_d;
      end
   end

   assign cc = cc_q;
`else
   logic unusedCcInputs;
   assign unusedCcInputs = ^{req0_setcc, req1_setcc, aluZf, aluSf, aluOf};
   assign cc             = 3'b000;
`endif

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: directed scenarios followed by randomized traffic
// checked against a transaction-level model of the arbiter, result slot and flags.
module tb_alu_arb;

   localparam int W = 64;
`ifdef ALU_ARB_CC_EN
   localparam bit CcOn = 1'b1;
`else
   localparam bit CcOn = 1'b0;
`endif
   localparam logic [2:0] CcRst = CcOn ? 3'b100 : 3'b000;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [1:0]   req0_fn, req1_fn;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         req0_setcc, req1_setcc;
   logic         res_valid, res_ready, res_id;
   logic [W-1:0] res_data;
   logic [2:0]   cc;

   int total = 0;
   int bad   = 0;

   // Model state: slot occupancy, its contents, whose turn it is on contention, flags.
   bit           mFull;
   logic [W-1:0] mData;
   bit           mId;
   int           mTurn;
   logic [2:0]   mCc;

   alu_arb #(.W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .req0_fn    (req0_fn),
      .req1_fn    (req1_fn),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req0_setcc (req0_setcc),
      .req1_setcc (req1_setcc),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_id     (res_id),
      .res_data   (res_data),
      .cc         (cc)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference arithmetic done in W+1 signed bits; overflow means the true sum does not fit in W.
   task automatic aluModel(input logic [1:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic [2:0] flags);
      logic signed [W:0] wa, wb, ws;
      logic              ovf;
      wa  = $signed({a[W-1], a});
      wb  = $signed({b[W-1], b});
      ws  = '0;
      ovf = 1'b0;
      case (fn)
         2'd0: begin ws = wb + wa; r = ws[W-1:0]; ovf = (ws[W] != ws[W-1]); end
         2'd1: begin ws = wb - wa; r = ws[W-1:0]; ovf = (ws[W] != ws[W-1]); end
         2'd2: r = a & b;
         default: r = a ^ b;
      endcase
      flags = {(r == '0), r[W-1], ovf};
   endtask

   function automatic int pickGrant();
      if (mFull && !res_ready) return -1;
      if (req0_valid && req1_valid) return mTurn;
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   task automatic modelReset();
      mFull = 0;
      mData = '0;
      mId   = 0;
      mTurn = 0;
      mCc   = CcRst;
   endtask

   // One clock: check combinational grants, advance the model at the edge, check registered outputs.
   task automatic applyStimulus(input string tag);
      int           g;
      logic [W-1:0] r;
      logic [2:0]   f;
      #1;
      g = pickGrant();
      checkOutput({tag, ".rdy0"}, W'(req0_ready), W'(g == 0));
      checkOutput({tag, ".rdy1"}, W'(req1_ready), W'(g == 1));
      @(posedge clk);
      if (g >= 0) begin
         if (g == 0) aluModel(req0_fn, req0_a, req0_b, r, f);
         else        aluModel(req1_fn, req1_a, req1_b, r, f);
         mFull = 1;
         mData = r;
         mId   = (g == 1);
         mTurn = 1 - g;
         if (CcOn && ((g == 0) ? req0_setcc : req1_setcc)) mCc = f;
      end else if (mFull && res_ready) begin
         mFull = 0;
      end
      @(negedge clk);
      checkOutput({tag, ".valid"}, W'(res_valid), W'(mFull));
      checkOutput({tag, ".data"}, res_data, mData);
      checkOutput({tag, ".id"}, W'(res_id), W'(mId));
      checkOutput({tag, ".cc"}, W'(cc), W'(mCc));
   endtask

   task automatic setReq(input int n, input logic v, input logic [1:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic sc);
      if (n == 0) begin
         req0_valid = v; req0_fn = fn; req0_a = a; req0_b = b; req0_setcc = sc;
      end else begin
         req1_valid = v; req1_fn = fn; req1_a = a; req1_b = b; req1_setcc = sc;
      end
   endtask

   function automatic logic [W-1:0] randOperand();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = '0;
         1:       v = {1'b0, {(W-1){1'b1}}};
         2:       v = {1'b1, {(W-1){1'b0}}};
         3:       v = W'($urandom_range(0, 3));
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   initial begin
      logic [W-1:0] held;
      logic [W-1:0] ra;
      setReq(0, 0, 2'd0, '0, '0, 0);
      setReq(1, 0, 2'd0, '0, '0, 0);
      res_ready = 0;
      rst       = 1;
      modelReset();

      // Reset state, with requests pending to show no grant leaks out during reset.
      @(negedge clk);
      req0_valid = 1;
      req1_valid = 1;
      #1;
      checkOutput("rst.rdy0", W'(req0_ready), '0);
      checkOutput("rst.rdy1", W'(req1_ready), '0);
      checkOutput("rst.valid", W'(res_valid), '0);
      checkOutput("rst.data", res_data, '0);
      checkOutput("rst.id", W'(res_id), '0);
      checkOutput("rst.cc", W'(cc), W'(CcRst));
      req0_valid = 0;
      req1_valid = 0;
      rst        = 0;
      @(negedge clk);

      // Single ADD from requester 0.
      setReq(0, 1, 2'd0, 64'd5, 64'd7, 1);
      applyStimulus("add");
      checkOutput("add.data12", res_data, 64'd12);
      checkOutput("add.id0", W'(res_id), '0);
      checkOutput("add.cc000", W'(cc), '0);

      // SUB to zero, then AND to zero without setcc; drain and accept together.
      setReq(0, 0, 2'd0, '0, '0, 0);
      res_ready = 1;
      setReq(1, 1, 2'd1, 64'd9, 64'd9, 1);
      applyStimulus("sub");
      checkOutput("sub.data0", res_data, '0);
      checkOutput("sub.cc", W'(cc), W'(CcOn ? 3'b100 : 3'b000));
      setReq(1, 1, 2'd2, 64'hF0, 64'h0F, 0);
      applyStimulus("and");
      checkOutput("and.data0", res_data, '0);
      checkOutput("and.cc", W'(cc), W'(CcOn ? 3'b100 : 3'b000));

      // Signed overflow on ADD.
      setReq(1, 0, 2'd0, '0, '0, 0);
      setReq(0, 1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1);
      applyStimulus("ovf");
      checkOutput("ovf.data", res_data, 64'hFFFF_FFFF_FFFF_FFFE);
      checkOutput("ovf.cc", W'(cc), W'(CcOn ? 3'b011 : 3'b000));

      // Lone request from 1 hands the next contention turn to requester 0.
      setReq(0, 0, 2'd0, '0, '0, 0);
      setReq(1, 1, 2'd3, 64'h55, 64'hFF, 0);
      applyStimulus("xor");

      // Contention: grants must alternate 0,1,0,1 with a result every cycle.
      for (int i = 0; i < 4; i++) begin
         setReq(0, 1, 2'd0, W'(i), 64'd100, 1);
         setReq(1, 1, 2'd1, W'(i), 64'd200, 1);
         #1;
         checkOutput("cont.gnt0", W'(req0_ready), W'(i % 2 == 0));
         checkOutput("cont.gnt1", W'(req1_ready), W'(i % 2 == 1));
         applyStimulus("cont");
         checkOutput("cont.valid", W'(res_valid), W'(1));
      end

      // Backpressure: full slot with no consumer must hold and grant nothing.
      res_ready = 0;
      held      = mData;
      for (int i = 0; i < 3; i++) begin
         applyStimulus("bp");
         checkOutput("bp.rdy0", W'(req0_ready), '0);
         checkOutput("bp.rdy1", W'(req1_ready), '0);
         checkOutput("bp.hold", res_data, held);
      end
      res_ready = 1;
      applyStimulus("bp.drain");

      // Asynchronous reset while full: slot cleared before any clock edge.
      #2;
      rst = 1;
      #1;
      checkOutput("arst.valid", W'(res_valid), '0);
      checkOutput("arst.cc", W'(cc), W'(CcRst));
      checkOutput("arst.data", res_data, '0);
      checkOutput("arst.rdy0", W'(req0_ready), '0);
      checkOutput("arst.rdy1", W'(req1_ready), '0);
      modelReset();
      @(negedge clk);
      setReq(0, 0, 2'd0, '0, '0, 0);
      setReq(1, 0, 2'd0, '0, '0, 0);
      rst = 0;
      @(negedge clk);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         ra = randOperand();
         setReq(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra,
                ($urandom_range(0, 7) == 0) ? ra : randOperand(), 1'($urandom_range(0, 1)));
         ra = randOperand();
         setReq(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra,
                ($urandom_range(0, 7) == 0) ? ra : randOperand(), 1'($urandom_range(0, 1)));
         res_ready = ($urandom_range(0, 9) < 7);
         applyStimulus("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 The block SHALL have parameter W, default 64, giving the datapath width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: the requester has an operation pending.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: grant; the operation is accepted this cycle.
REQ-006 The block SHALL have ports req0_fn and req1_fn, input, 2 bits each: the function code.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, W bits each: the operands (valA, valB).
REQ-008 The block SHALL have ports req0_setcc and req1_setcc, input, 1 bit each: update the condition codes with this result.
REQ-009 The block SHALL have port res_valid, output, 1 bit: the result slot is full.
REQ-010 The block SHALL have port res_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port res_id, output, 1 bit: the index of the requester that owns the result.
REQ-012 The block SHALL have port res_data, output, W bits: the registered result.
REQ-013 The block SHALL have port cc, output, 3 bits, ordered {ZF, SF, OF}: the condition-code register.

Function
REQ-014 The function codes SHALL be: 0 ADD (b+a), 1 SUB (b-a), 2 AND (a&b), 3 XOR (a^b), all modulo 2^W.
REQ-015 The result slot SHALL be a two-state FSM, EMPTY or FULL, with res_valid=1 exactly when the state is FULL.
REQ-016 A grant SHALL be possible only when the state is EMPTY, or when it is FULL and res_ready=1 (drain and accept in the same cycle).
REQ-017 When a grant is possible and only one req is valid, that requester SHALL be granted.
REQ-018 When a grant is possible and both reqs are valid, the requester selected by rr_ptr SHALL be granted.
REQ-019 After every grant, rr_ptr SHALL be set to the non-granted index.
REQ-020 reqN_ready SHALL be combinational, at most one SHALL be high per cycle, and it SHALL never be high while reqN_valid=0.
REQ-021 On an accept edge, res_data, res_id and state=FULL SHALL be loaded, giving 1-cycle latency and a throughput of 1 op per cycle.
REQ-022 A drain with no accept SHALL set state=EMPTY; res_data and res_id SHALL hold their last values.
REQ-023 While FULL and res_ready=0, res_data and res_id SHALL be held stable and no grant SHALL be issued.
REQ-024 The condition codes SHALL be computed from the accepted op as follows:
- ZF: result == 0.
- SF: result[W-1].
- OF for ADD: a and b have the same sign and the result sign differs.
- OF for SUB: a and b differ in sign and the result sign differs from b.
- OF for AND and XOR: 0.
REQ-025 cc SHALL load on an accept edge only if the granted setcc=1; otherwise cc SHALL hold.

Reset
REQ-026 When rst=1, the block SHALL immediately set state=EMPTY, res_valid=0, res_data=0, res_id=0, rr_ptr=0 and cc=3'b100.
REQ-027 While rst=1, both reqN_ready outputs SHALL be 0.
REQ-028 A result pending when reset is asserted SHALL be discarded.

Configuration
REQ-029 When ALU_ARB_CC_EN is defined, the block SHALL include the cc register and the setcc logic as specified above.
REQ-030 When ALU_ARB_CC_EN is not defined, cc SHALL be the constant 3'b000, setcc SHALL be ignored, and no flag logic SHALL be present.

Structure
REQ-031 The fn encodings, the cc bit indices and the cc reset value SHALL be defined in the shared package y86_pkg.
REQ-032 The combinational ALU SHALL be a single sub-module, alu_core, with inputs a, b and fn and outputs result, zf, sf and of; the arbiter logic and the registers SHALL stay in alu_arb.

Verification
REQ-033 Single op: req0 ADD a=5, b=7, setcc=1 -> req0_ready=1 in the same cycle; next cycle res_valid=1, res_data=12, res_id=0, cc=000.
REQ-034 SUB to zero: req1 SUB a=9, b=9, setcc=1 -> res_data=0, cc=100; then AND 0xF0 with 0x0F and setcc=0 -> res_data=0, cc still 100.
REQ-035 Signed overflow: ADD a=b=0x7FFF_FFFF_FFFF_FFFF with setcc -> res_data=0xFFFF_FFFF_FFFF_FFFE, cc=011.
REQ-036 Contention: both reqs valid for 4 cycles with res_ready=1 -> grants alternate 0,1,0,1 and one res_valid per cycle.
REQ-037 Backpressure and reset: res_ready=0 for 3 cycles -> no grants and res_data stable; res_ready=1 -> drain and accept in one cycle; rst mid-FULL -> res_valid=0 immediately and cc=100.
